// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants for the interrupt source controller.
//   - Register word addresses on the 3-bit register bus.
//   - TCTRL bit positions.
//   - Dispatch FSM state encoding.
package irq_ctrl_pkg;

  localparam logic [2:0] IRQ_PEND  = 3'd0;
  localparam logic [2:0] IRQ_MASK  = 3'd1;
  localparam logic [2:0] IRQ_STAT  = 3'd2;
  localparam logic [2:0] IRQ_TCMP  = 3'd3;
  localparam logic [2:0] IRQ_TCNT  = 3'd4;
  localparam logic [2:0] IRQ_TCTRL = 3'd5;

  localparam int unsigned TCTRL_EN   = 0;
  localparam int unsigned TCTRL_AUTO = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_timer.sv
// irq_timer: compare timer feeding interrupt source 0.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_wr_en               qualified register write strobe
//   i_addr, i_wdata       register word address and write data
//   o_tcmp, o_tcnt        compare value and running count
//   o_tctrl               {AUTO, EN}
//   o_match               high in the cycle where EN is set and TCNT == TCMP
module irq_timer
  import irq_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_tcmp,
  output logic [31:0] o_tcnt,
  output logic [1:0]  o_tctrl,
  output logic        o_match
);

  logic [31:0] r_tcmp, r_tcnt;
  logic [1:0]  r_tctrl;
  logic [31:0] w_tcmp_d, w_tcnt_d;
  logic [1:0]  w_tctrl_d;
  logic        w_match;

  assign w_match = r_tctrl[TCTRL_EN] && (r_tcnt == r_tcmp);

  always_comb begin
    w_tcmp_d  = r_tcmp;
    w_tcnt_d  = r_tcnt;
    w_tctrl_d = r_tctrl;
    if (r_tctrl[TCTRL_EN]) begin
      if (w_match) begin
        // Auto mode restarts from zero; one-shot freezes the count and stops.
        if (r_tctrl[TCTRL_AUTO]) w_tcnt_d = '0;
        else                     w_tctrl_d[TCTRL_EN] = 1'b0;
      end else begin
        w_tcnt_d = r_tcnt + 32'd1;
      end
    end
    // Software writes take precedence over the timer's own update.
    if (i_wr_en) begin
      case (i_addr)
        IRQ_TCMP:  w_tcmp_d  = i_wdata;
        IRQ_TCNT:  w_tcnt_d  = i_wdata;
        IRQ_TCTRL: w_tctrl_d = i_wdata[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tcmp  <= 32'hFFFF_FFFF;
      r_tcnt  <= '0;
      r_tctrl <= '0;
    end else begin
      r_tcmp  <= w_tcmp_d;
      r_tcnt  <= w_tcnt_d;
      r_tctrl <= w_tctrl_d;
    end
  end

  assign o_tcmp  = r_tcmp;
  assign o_tcnt  = r_tcnt;
  assign o_tctrl = r_tctrl;
  assign o_match = w_match;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt source controller driving CP0's external interrupt input.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_src_in               level request lines (bit 0 unused, timer owns source 0)
//   i_bus_en, i_bus_we     register access strobe and write select
//   i_bus_addr, i_bus_wdata word address and write data
//   o_bus_rdata            combinational read data, 0 for unmapped addresses
//   i_eret                 one-cycle ERET pulse from CP0
//   o_ir_out               one-cycle request pulse per dispatch
//   o_irq_id               id of the dispatched / in-service interrupt
//   o_busy                 high while a dispatched interrupt awaits ERET
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NSRC = 8,
  parameter int unsigned IDW  = $clog2(NSRC)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NSRC-1:0] i_src_in,
  input  logic            i_bus_en,
  input  logic            i_bus_we,
  input  logic [2:0]      i_bus_addr,
  input  logic [31:0]     i_bus_wdata,
  output logic [31:0]     o_bus_rdata,
  input  logic            i_eret,
  output logic            o_ir_out,
  output logic [IDW-1:0]  o_irq_id,
  output logic            o_busy
);

  irq_state_e      r_state, w_state_d;
  logic [NSRC-1:0] r_pend, r_mask, r_src_prev;
  logic [IDW-1:0]  r_irq_id;
  logic [NSRC-1:0] w_edge, w_set, w_clr, w_pend_en;
  logic [IDW-1:0]  w_pick_id;
  logic            w_dispatch, w_bus_wr, w_match;
  logic [31:0]     w_tcmp, w_tcnt;
  logic [1:0]      w_tctrl;

  assign w_bus_wr = i_bus_en & i_bus_we;

  irq_timer u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr_en (w_bus_wr),
    .i_addr  (i_bus_addr),
    .i_wdata (i_bus_wdata),
    .o_tcmp  (w_tcmp),
    .o_tcnt  (w_tcnt),
    .o_tctrl (w_tctrl),
    .o_match (w_match)
  );

  // Bit 0 of the source lines is replaced by the timer match.
  assign w_edge    = i_src_in & ~r_src_prev;
  assign w_set     = (w_edge & ~NSRC'(1)) | NSRC'(w_match);
  assign w_pend_en = r_pend & r_mask;

  // Lowest set index wins.
  always_comb begin
    w_pick_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_pend_en[i]) w_pick_id = IDW'(i);
    end
  end

  assign w_dispatch = (r_state == IDLE) && (|w_pend_en);

  always_comb begin
    w_clr = '0;
    if (w_bus_wr && (i_bus_addr == IRQ_PEND)) w_clr = i_bus_wdata[NSRC-1:0];
    if (w_dispatch) w_clr = w_clr | (NSRC'(1) << w_pick_id);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend     <= '0;
      r_mask     <= '0;
      r_src_prev <= '0;
      r_irq_id   <= '0;
    end else begin
      r_src_prev <= i_src_in;
      // A new event in the same cycle as a clear keeps the bit set.
      r_pend     <= (r_pend & ~w_clr) | w_set;
      if (w_bus_wr && (i_bus_addr == IRQ_MASK)) r_mask <= i_bus_wdata[NSRC-1:0];
      if (w_dispatch) r_irq_id <= w_pick_id;
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_d;
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (w_dispatch) w_state_d = REQ;
      REQ:     w_state_d = SERV;
      SERV:    if (i_eret) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // FSM: outputs, decoded straight from the state register
  always_comb begin
    o_ir_out = (r_state == REQ);
    o_busy   = (r_state == REQ) || (r_state == SERV);
  end

  assign o_irq_id = r_irq_id;

  always_comb begin
    o_bus_rdata = '0;
    case (i_bus_addr)
      IRQ_PEND:  o_bus_rdata = 32'(r_pend);
      IRQ_MASK:  o_bus_rdata = 32'(r_mask);
      IRQ_STAT: begin
        o_bus_rdata     = 32'(r_irq_id);
        o_bus_rdata[31] = o_busy;
      end
      IRQ_TCMP:  o_bus_rdata = w_tcmp;
      IRQ_TCNT:  o_bus_rdata = w_tcnt;
      IRQ_TCTRL: o_bus_rdata = 32'(w_tctrl);
      default:   o_bus_rdata = '0;
    endcase
  end

endmodule
